// File: rtl/lstm_ctrl_pkg.sv
// Shared types and reset defaults for the LSTM accelerator enable scheduler.
package lstm_ctrl_pkg;

  localparam int unsigned DIV_W_DEF      = 8;
  localparam int unsigned CELL_CNT_W_DEF = 16;
  localparam int unsigned PE_DIV_RST     = 8;
  localparam int unsigned CELL_DIV_RST   = 9;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} sched_state_t;

endpackage

// File: rtl/clk_en_sched_if.sv
// Config handshake, run control and enable/status outputs of the enable scheduler.
interface clk_en_sched_if #(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned CELL_CNT_W = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DIV_W-1:0]      cfg_pe_div;
  logic [DIV_W-1:0]      cfg_cell_div;
  logic [CELL_CNT_W-1:0] cfg_n_cells;
  logic                  start;
  logic                  stop;
  logic                  pe_en;
  logic                  cell_en;
  logic                  busy;
  logic                  done;
  logic [CELL_CNT_W-1:0] cell_idx;

  modport master (
    output cfg_valid, cfg_pe_div, cfg_cell_div, cfg_n_cells, start, stop,
    input  cfg_ready, pe_en, cell_en, busy, done, cell_idx
  );

  modport slave (
    input  cfg_valid, cfg_pe_div, cfg_cell_div, cfg_n_cells, start, stop,
    output cfg_ready, pe_en, cell_en, busy, done, cell_idx
  );
endinterface

// File: rtl/en_div_cnt.sv
// Divide-by-N counter producing a registered one-cycle strobe every div_i cycles while running.
module en_div_cnt #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             strobe_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, last;
  logic             strobe_q, strobe_d;

  // Ratios 0 and 1 both mean "every cycle".
  assign last = (div_i < DIV_W'(2)) ? '0 : div_i - 1'b1;

  // Strobe is registered from the next count so it lines up with counter == last.
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (clear_i) begin
      cnt_d    = '0;
      strobe_d = (last == '0);
    end else if (run_i) begin
      cnt_d    = (cnt_q == last) ? '0 : cnt_q + 1'b1;
      strobe_d = (cnt_d == last);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;
endmodule

// File: rtl/clk_en_sched.sv
// Single-clock enable scheduler: pe_en / cell_en strobes on sys_clk with run-length control.
module clk_en_sched
  import lstm_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W        = DIV_W_DEF,
  parameter int unsigned CELL_CNT_W   = CELL_CNT_W_DEF,
  parameter int unsigned PE_DIV_DEF   = PE_DIV_RST,
  parameter int unsigned CELL_DIV_DEF = CELL_DIV_RST
) (
  input logic           sys_clk,
  input logic           reset,
  clk_en_sched_if.slave bus
);
  sched_state_t          state_q, state_d;
  logic [DIV_W-1:0]      pe_div_q, pe_div_d, cell_div_q, cell_div_d;
  logic [CELL_CNT_W-1:0] n_cells_q, n_cells_d;
  logic [CELL_CNT_W-1:0] cell_idx_q, cell_idx_d, cell_idx_inc;
  logic                  busy_q, done_q, cfg_ready_q;
  logic                  cfg_we, start_run, run_d, last_cell;
  logic                  pe_en, cell_en;

  assign cfg_we       = bus.cfg_valid && (state_q == S_IDLE);
  assign start_run    = bus.start && (state_q == S_IDLE);
  assign cell_idx_inc = cell_idx_q + 1'b1;
  assign last_cell    = cell_en && (n_cells_q != '0) && (cell_idx_inc == n_cells_q);
  assign run_d        = (state_d == S_RUN) || (state_d == S_DRAIN);

  always_comb begin
    pe_div_d   = pe_div_q;
    cell_div_d = cell_div_q;
    n_cells_d  = n_cells_q;
    if (cfg_we) begin
      pe_div_d   = bus.cfg_pe_div;
      cell_div_d = bus.cfg_cell_div;
      n_cells_d  = bus.cfg_n_cells;
    end
  end

  always_comb begin
    state_d    = state_q;
    cell_idx_d = cell_en ? cell_idx_inc : cell_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_RUN;
          cell_idx_d = '0;
        end
      end
      // A final cell_en takes priority over a coincident stop.
      S_RUN: begin
        if (last_cell)     state_d = S_DONE;
        else if (bus.stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cell_en) state_d = S_IDLE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cell_idx_q  <= '0;
      pe_div_q    <= DIV_W'(PE_DIV_DEF);
      cell_div_q  <= DIV_W'(CELL_DIV_DEF);
      n_cells_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      cfg_ready_q <= (state_d == S_IDLE);
      cell_idx_q  <= cell_idx_d;
      pe_div_q    <= pe_div_d;
      cell_div_q  <= cell_div_d;
      n_cells_q   <= n_cells_d;
    end
  end

  // Dividers see the next-state ratio so a config written with start is used immediately.
  en_div_cnt #(
    .DIV_W (DIV_W)
  ) u_pe_div (
    .clk_i    (sys_clk),
    .rst_i    (reset),
    .clear_i  (start_run),
    .run_i    (run_d),
    .div_i    (pe_div_d),
    .strobe_o (pe_en)
  );

  en_div_cnt #(
    .DIV_W (DIV_W)
  ) u_cell_div (
    .clk_i    (sys_clk),
    .rst_i    (reset),
    .clear_i  (start_run),
    .run_i    (run_d),
    .div_i    (cell_div_d),
    .strobe_o (cell_en)
  );

  assign bus.pe_en     = pe_en;
  assign bus.cell_en   = cell_en;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cell_idx  = cell_idx_q;
endmodule

// File: tb/tb_clk_en_sched.sv
// Scoreboard bench for clk_en_sched: expected strobe cycles queued at start, checked as they occur.
module tb_clk_en_sched;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  clk_en_sched_if #(.DIV_W(8), .CELL_CNT_W(16)) bus ();

  clk_en_sched dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_pe[$];
  int exp_cell[$];
  int exp_done[$];
  int t0, busy_end, exp_idx;
  bit run_active = 1'b0;
  int m_pd = 8, m_cd = 9, m_n = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe/done events are compared against the cycle offset from the start cycle.
  always @(negedge clk) begin : mon
    int cur, e;
    if (run_active) begin
      cur = cyc - t0;
      if (bus.pe_en) begin
        e = (exp_pe.size() != 0) ? exp_pe.pop_front() : -1;
        check_eq("pe_en_cycle", cur, e);
      end
      if (bus.cell_en) begin
        e = (exp_cell.size() != 0) ? exp_cell.pop_front() : -1;
        check_eq("cell_en_cycle", cur, e);
      end
      if (bus.done) begin
        e = (exp_done.size() != 0) ? exp_done.pop_front() : -1;
        check_eq("done_cycle", cur, e);
      end
      check_eq("busy", bus.busy, (cur >= 1 && cur <= busy_end));
    end else if (bus.pe_en || bus.cell_en || bus.done) begin
      check_eq("idle_strobe", {bus.pe_en, bus.cell_en, bus.done}, 0);
    end
  end

  task automatic cfg_write(input int pd, input int cd, input int n);
    check_eq("cfg_ready_idle", bus.cfg_ready, 1);
    bus.cfg_valid    = 1'b1;
    bus.cfg_pe_div   = 8'(pd);
    bus.cfg_cell_div = 8'(cd);
    bus.cfg_n_cells  = 16'(n);
    m_pd = pd; m_cd = cd; m_n = n;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // stop_at: cycle stop is high (-1 = together with start, 0 = never); abort_at: reset cycle;
  // bcfg_at: cycle a config write is attempted while busy.
  task automatic run(input bit wr, input int pd, input int cd, input int n,
                     input int stop_at, input int abort_at, input int bcfg_at);
    int epd, ecd, end_c, cut, lim, cnt;
    bit has_done;
    if (wr) begin
      bus.cfg_valid    = 1'b1;
      bus.cfg_pe_div   = 8'(pd);
      bus.cfg_cell_div = 8'(cd);
      bus.cfg_n_cells  = 16'(n);
      m_pd = pd; m_cd = cd; m_n = n;
    end
    epd = (m_pd < 2) ? 1 : m_pd;
    ecd = (m_cd < 2) ? 1 : m_cd;
    if (m_n != 0 && (stop_at <= 0 || m_n * ecd <= stop_at)) begin
      end_c = m_n * ecd; has_done = 1'b1;
    end else if (stop_at > 0) begin
      end_c = (stop_at / ecd + 1) * ecd; has_done = 1'b0;
    end else begin
      end_c = 1 << 20; has_done = 1'b0;
    end
    cut      = (abort_at > 0) ? abort_at : end_c + 1;
    busy_end = has_done ? end_c + 1 : end_c;
    if (abort_at > 0 && abort_at < busy_end) busy_end = abort_at;
    for (int k = epd; k <= end_c && k <= cut; k += epd) exp_pe.push_back(k);
    cnt = 0;
    for (int k = ecd; k <= end_c && k <= cut; k += ecd) begin
      exp_cell.push_back(k);
      cnt++;
    end
    if (has_done && end_c + 1 <= cut) exp_done.push_back(end_c + 1);
    exp_idx = (abort_at > 0) ? 0 : cnt;

    bus.start  = 1'b1;
    bus.stop   = (stop_at < 0);
    t0         = cyc;
    run_active = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.cfg_valid = 1'b0;
    lim = busy_end + 2;
    for (int i = 1; i <= lim; i++) begin
      bus.stop = (i == stop_at);
      rst      = (i == abort_at);
      bus.cfg_valid = (i == bcfg_at);
      if (i == bcfg_at) begin
        bus.cfg_pe_div   = 8'd1;
        bus.cfg_cell_div = 8'd1;
        bus.cfg_n_cells  = 16'd7;
        check_eq("cfg_ready_busy", bus.cfg_ready, 0);
      end
      if (abort_at > 0 && i == abort_at + 1) begin
        check_eq("rst_pe_en", bus.pe_en, 0);
        check_eq("rst_cell_en", bus.cell_en, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_cfg_ready", bus.cfg_ready, 1);
        check_eq("rst_cell_idx", bus.cell_idx, 0);
      end
      tick();
    end
    bus.stop = 1'b0;
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    if (abort_at > 0) begin
      m_pd = 8; m_cd = 9; m_n = 0;
    end
    run_active = 1'b0;
    check_eq("cell_idx_end", bus.cell_idx, exp_idx);
    check_eq("busy_after", bus.busy, 0);
    check_eq("cfg_ready_after", bus.cfg_ready, 1);
    check_eq("pe_left", exp_pe.size(), 0);
    check_eq("cell_left", exp_cell.size(), 0);
    check_eq("done_left", exp_done.size(), 0);
    exp_pe.delete();
    exp_cell.delete();
    exp_done.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_pe_div = '0;
    bus.cfg_cell_div = '0;
    bus.cfg_n_cells = '0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_cfg_ready", bus.cfg_ready, 1);
    check_eq("rst_cell_idx", bus.cell_idx, 0);
    check_eq("rst_strobes", {bus.pe_en, bus.cell_en, bus.done}, 0);

    run(1'b0, 0, 0, 0, 40, 0, 0);   // defaults 8/9 free-run, stop drains to cell 45
    run(1'b1, 2, 6, 3, -1, 0, 0);   // start+stop in IDLE: stop ignored, done after 3 cells
    run(1'b1, 0, 1, 4, 0, 0, 0);    // ratios 0 and 1 strobe every cycle
    run(1'b1, 1, 5, 0, 7, 0, 0);    // stop mid-run drains to next cell_en
    run(1'b1, 3, 4, 2, 0, 0, 3);    // config attempt while busy is ignored
    run(1'b0, 0, 0, 0, 0, 0, 0);    // same 3/4/2 reused
    cfg_write(4, 0, 5);             // write in IDLE, used by following start
    run(1'b0, 0, 0, 0, 0, 0, 0);
    run(1'b1, 2, 3, 2, 6, 0, 0);    // stop coincident with final cell_en: done wins
    run(1'b1, 0, 3, 0, 6, 0, 0);    // stop on non-final cell_en waits for the next one
    run(1'b1, 5, 7, 0, 0, 12, 0);   // reset mid-run
    run(1'b0, 0, 0, 0, 20, 0, 0);   // config back at 8/9/0

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
